// File: rtl/array_uart_receiver_pkg.sv
// Shared types and constants for the array UART receiver (and its transmit twin).
package array_uart_pkg;

  // Data bits per UART character, common to both directions of the link.
  localparam int UART_DATA_BITS = 8;

  // Byte-level receive states; RX_PARITY is only visited in 8E1 builds.
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // Whole clock cycles per bit period (truncating division).
  function automatic int clks_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/array_uart_receiver_rx_byte.sv
// Single-character UART receiver: 2-FF synchronizer, start/data/stop FSM.
// Defining UART_RX_PARITY_EN adds an even-parity bit (8E1); otherwise 8N1.
// byte_valid / byte_error are single-cycle strobes in the cycle of the
// deciding sample so the word assembler can register them one cycle later.
module uart_rx_byte
  import array_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      uart_rx,
  output logic [UART_DATA_BITS-1:0] byte_data,
  output logic                      byte_valid,
  output logic                      byte_error,
  output logic                      rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

  logic                      rx_p0, rx_p1, rx_p2;
  rx_state_t                 state;
  logic [CW-1:0]             clk_cnt;
  logic [2:0]                bit_cnt;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      tick;

  assign tick = (clk_cnt == BIT_LAST);

  // Synchronizer: rx_p1 is the synchronized line, rx_p2 its previous value for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= uart_rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  // Byte FSM: start edge, mid-bit start check, data bits, optional parity, stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RX_IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        RX_IDLE: begin
          if (rx_p2 && !rx_p1) begin
            state   <= RX_START;
            clk_cnt <= '0;
            bit_cnt <= '0;
          end
        end
        RX_START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            state   <= rx_p1 ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (tick) begin
            clk_cnt <= '0;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state <= RX_PARITY;
`else
              state <= RX_STOP;
`endif
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        RX_PARITY: begin
          if (tick) begin
            clk_cnt <= '0;
            state   <= (^{shift, rx_p1}) ? RX_IDLE : RX_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`endif
        RX_STOP: begin
          if (tick) begin
            clk_cnt <= '0;
            state   <= RX_IDLE;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  // Data shifter: LSB arrives first, so shift in from the top.
  always_ff @(posedge clk) begin
    if (state == RX_DATA && tick) shift <= {rx_p1, shift[UART_DATA_BITS-1:1]};
  end

  assign byte_data  = shift;
  assign byte_valid = (state == RX_STOP) && tick && rx_p1;
`ifdef UART_RX_PARITY_EN
  assign byte_error = ((state == RX_STOP) && tick && !rx_p1) ||
                      ((state == RX_PARITY) && tick && (^{shift, rx_p1}));
`else
  assign byte_error = (state == RX_STOP) && tick && !rx_p1;
`endif
  assign rx_busy    = (state != RX_IDLE);

endmodule

// File: rtl/array_uart_receiver.sv
// Multi-byte UART word receiver: assembles NUM_BYTES characters (first byte
// ends up in the top bits) into data_array, with an inter-byte idle timeout.
// Build option UART_RX_PARITY_EN selects 8E1 framing in uart_rx_byte.
module array_uart_receiver
  import array_uart_pkg::*;
#(
  parameter int CLOCK_FREQ   = 50_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int NUM_BYTES    = 4,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                uart_rx,
  output logic [UART_DATA_BITS*NUM_BYTES-1:0] data_array,
  output logic                                data_valid,
  output logic                                frame_error,
  output logic                                busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int WORD_W       = UART_DATA_BITS * NUM_BYTES;
  localparam int BC_W         = $clog2(NUM_BYTES + 1);
  localparam int TO_COUNT     = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W         = $clog2(TO_COUNT + 1);

  logic [UART_DATA_BITS-1:0] byte_data;
  logic                      byte_valid, byte_error, rx_busy;
  logic [BC_W-1:0]           byte_cnt;
  logic [TO_W-1:0]           idle_timer;
  logic [WORD_W-1:0]         shadow, word_next;
  logic                      timeout_hit;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx_byte (
    .clk        (clk),
    .rst        (rst),
    .uart_rx    (uart_rx),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_error (byte_error),
    .rx_busy    (rx_busy)
  );

  // Shadow needs no clearing: a full word shifts every stale byte out.
  assign word_next   = WORD_W'({shadow, byte_data});
  assign timeout_hit = (byte_cnt != '0) && !rx_busy &&
                       (idle_timer == TO_W'(TO_COUNT - 1));
  assign busy        = rx_busy || (byte_cnt != '0);

  // Shadow register collects good bytes from the bottom.
  always_ff @(posedge clk) begin
    if (byte_valid) shadow <= word_next;
  end

  // Idle timer runs only between bytes of a partially received word.
  always_ff @(posedge clk) begin
    if (rst || rx_busy || (byte_cnt == '0) || timeout_hit) idle_timer <= '0;
    else                                                   idle_timer <= idle_timer + 1'b1;
  end

  // Word assembly and registered outputs; errors drop the partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt    <= '0;
      data_array  <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      if (byte_error || timeout_hit) begin
        frame_error <= 1'b1;
        byte_cnt    <= '0;
      end else if (byte_valid) begin
        if (byte_cnt == BC_W'(NUM_BYTES - 1)) begin
          data_array <= word_next;
          data_valid <= 1'b1;
          byte_cnt   <= '0;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_array_uart_receiver.sv
// Scoreboard bench for array_uart_receiver: expected pulse events are queued
// as frames are driven and matched against data_valid / frame_error pulses.
module tb_array_uart_receiver;

  localparam int CLOCK_FREQ   = 4_300_000;
  localparam int BAUD_RATE    = 100_000;
  localparam int NUM_BYTES    = 4;
  localparam int TIMEOUT_BITS = 20;
  localparam int CPB          = 43;
  localparam int W            = 8 * NUM_BYTES;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         uart_rx = 1'b1;
  logic [W-1:0] data_array;
  logic         data_valid, frame_error, busy;

  int           vec_cnt = 0;
  int           err_cnt = 0;
  logic [W:0]   exp_q[$];
  logic [W-1:0] model_word = '0;

  always #5 clk = ~clk;

  array_uart_receiver #(
    .CLOCK_FREQ   (CLOCK_FREQ),
    .BAUD_RATE    (BAUD_RATE),
    .NUM_BYTES    (NUM_BYTES),
    .TIMEOUT_BITS (TIMEOUT_BITS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .uart_rx     (uart_rx),
    .data_array  (data_array),
    .data_valid  (data_valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, need 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    uart_rx = v;
    repeat (CPB) @(negedge clk);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop_v);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(stop_v);
    uart_rx = 1'b1;
  endtask
`endif

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
`ifdef UART_RX_PARITY_EN
    send_frame(b, ^b, stop_v);
`else
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_v);
    uart_rx = 1'b1;
`endif
  endtask

  task automatic send_word(input logic [W-1:0] w);
    exp_q.push_back({1'b0, w});
    model_word = w;
    for (int i = NUM_BYTES - 1; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic expect_error();
    exp_q.push_back({1'b1, model_word});
  endtask

  task automatic wait_drain(input string tag, input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  // Monitor: every output pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && (data_valid || frame_error)) begin
      check("pulse_exclusive", {63'd0, data_valid & frame_error}, 64'd0);
      if (exp_q.size() == 0) begin
        check("spurious_pulse", {31'd0, frame_error, data_array}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check("event", {31'd0, frame_error, data_array}, {31'd0, e});
      end
    end
  end

  initial begin
    repeat (60000) @(negedge clk);
    $display("FAIL watchdog: got timeout, need completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] part;
    repeat (3) @(negedge clk);
    check("rst_data_array", data_array, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_frame_error", frame_error, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Basic word, zero inter-byte gap
    send_word(32'hDEAD_BEEF);
    wait_drain("word_deadbeef", 4);
    check("busy_after_deadbeef", busy, 0);

    // Bad stop bit on second byte, then a clean word
    expect_error();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    wait_drain("stop_error", 4);
    repeat (2 * CPB) @(negedge clk);
    check("busy_after_stop_err", busy, 0);
    send_word(32'h0102_0304);
    wait_drain("word_01020304", 4);

    // Short glitch on the line: START rejects it silently
    uart_rx = 1'b0;
    repeat (10) @(negedge clk);
    uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    check("busy_in_glitch", busy, 1);
    repeat (2 * CPB) @(negedge clk);
    check("busy_after_glitch", busy, 0);
    check("glitch_no_event", exp_q.size(), 0);

    // Inter-byte timeout after two bytes
    expect_error();
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    check("busy_partial_word", busy, 1);
    repeat (19 * CPB) @(negedge clk);
    check("timeout_not_early", exp_q.size(), 1);
    wait_drain("timeout", 2 * CPB);
    check("busy_after_timeout", busy, 0);
    send_word(32'hCAFE_F00D);
    wait_drain("word_cafef00d", 4);

    // Reset in the middle of bit 4 of byte 3
    part = 8'h56;
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(part[i]);
    uart_rx = part[4];
    repeat (CPB / 2) @(negedge clk);
    check("busy_mid_byte", busy, 1);
    rst = 1'b1;
    uart_rx = 1'b1;
    @(negedge clk);
    check("midrst_data_array", data_array, 0);
    check("midrst_data_valid", data_valid, 0);
    check("midrst_frame_error", frame_error, 0);
    check("midrst_busy", busy, 0);
    rst = 1'b0;
    model_word = '0;
    repeat (3 * CPB) @(negedge clk);
    send_word(32'hA5C3_3C5A);
    wait_drain("word_after_reset", 4);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 needs parity bit 1
    expect_error();
    send_frame(8'h07, 1'b0, 1'b1);
    wait_drain("parity_error", 4);
    repeat (2 * CPB) @(negedge clk);
    send_word(32'h0707_0707);
    wait_drain("parity_good_word", 4);
`endif

    repeat (2 * CPB) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_busy", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
